// File: rtl/riscv_mc_seq.sv
// Multi-cycle RISC-V control sequencer.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// raises the datapath strobes for each step, counts retired instructions
// and parks in HALT on EBREAK or an unrecognised opcode.
module riscv_mc_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        is_ebreak,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        imem_gnt,
  input  logic        dmem_gnt,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic [2:0]  state_reg;
  logic [2:0]  state_next;
  logic        illegal_reg;
  logic        illegal_next;
  logic [31:0] instret_reg;
  logic        legal_op;

  // Recognise the base RV32I major opcodes; everything else is illegal.
  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
      7'b0110011, 7'b0001111, 7'b1110011: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  // Next-state logic plus the two strobes that react to grants/decode in the same cycle.
  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (imem_gnt) begin
          ir_we      = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_ebreak) begin
          state_next = ST_HALT;
        end else if (!legal_op) begin
          state_next   = ST_HALT;
          illegal_next = 1'b1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (mem_read || mem_write) begin
          state_next = ST_MEM;
        end else if (reg_write) begin
          state_next = ST_WB;
        end else begin
          // Branch, FENCE, ECALL: nothing left to do but move the PC.
          pc_we      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_gnt) begin
          if (mem_read) begin
            state_next = ST_WB;
          end else begin
            pc_we      = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        pc_we      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        // Unused encodings recover to a fresh fetch.
        state_next = ST_FETCH;
      end
    endcase
  end

  // State, sticky illegal flag and retire counter; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      illegal_reg <= 1'b0;
      instret_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (pc_we) begin
        instret_reg <= instret_reg + 32'd1;
      end
    end
  end

  // Pure state decodes, so they are glitch-free w.r.t. the inputs.
  assign imem_req = (state_reg == ST_FETCH);
  assign dmem_req = (state_reg == ST_MEM);
  assign rf_we    = (state_reg == ST_WB);
  assign halted   = (state_reg == ST_HALT);
  assign illegal  = illegal_reg;
  assign state    = state_reg;
  assign instret  = instret_reg;

endmodule

// File: tb/tb_riscv_mc_seq.sv
// Directed bench for riscv_mc_seq: per-cycle state/strobe traces from a
// table of hand-derived vectors, plus sequences for reset-in-MEM,
// instret wrap and recovery from an unused state encoding.
module tb_riscv_mc_seq;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        is_ebreak;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        imem_gnt;
  logic        dmem_gnt;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_req;
  logic        pc_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;
  logic [31:0] instret;

  int checks;
  int failures;

  riscv_mc_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .is_ebreak (is_ebreak),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .imem_gnt  (imem_gnt),
    .dmem_gnt  (dmem_gnt),
    .imem_req  (imem_req),
    .ir_we     (ir_we),
    .dmem_req  (dmem_req),
    .pc_we     (pc_we),
    .rf_we     (rf_we),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction: controls, per-cycle grant masks, expected state trace
  // (nibble i = state in cycle i) and expected strobe masks (bit i = cycle i).
  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        ebreak;
    logic        mr;
    logic        mw;
    logic        rw;
    int          ncyc;
    logic [15:0] imask;
    logic [15:0] dmask;
    logic [63:0] trace;
    logic [15:0] irmask;
    logic [15:0] pcmask;
    logic [15:0] rfmask;
    logic        ill;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx);
    logic [2:0] exp_st;
    logic [9:0] act_b;
    logic [9:0] exp_b;
    int         f0;
    f0 = failures;
    do_reset();
    opcode    = vecs[idx].op;
    is_ebreak = vecs[idx].ebreak;
    mem_read  = vecs[idx].mr;
    mem_write = vecs[idx].mw;
    reg_write = vecs[idx].rw;
    for (int i = 0; i < vecs[idx].ncyc; i++) begin
      imem_gnt = vecs[idx].imask[i];
      dmem_gnt = vecs[idx].dmask[i];
      #1;
      exp_st = vecs[idx].trace[4*i +: 3];
      exp_b  = {exp_st, exp_st == 3'd0, vecs[idx].irmask[i], exp_st == 3'd3,
                vecs[idx].pcmask[i], vecs[idx].rfmask[i], exp_st == 3'd5,
                (exp_st == 3'd5) && vecs[idx].ill};
      act_b  = {state, imem_req, ir_we, dmem_req, pc_we, rf_we, halted, illegal};
      chk($sformatf("%s cyc%0d {st,ireq,irwe,dreq,pcwe,rfwe,halt,ill}", vecs[idx].name, i),
          {22'd0, act_b}, {22'd0, exp_b});
      tick();
    end
    imem_gnt = 1'b0;
    dmem_gnt = 1'b0;
    chk($sformatf("%s instret", vecs[idx].name), instret, vecs[idx].ret);
    $display("vec %-10s cycles=%0d instret=%0d errors=%0d",
             vecs[idx].name, vecs[idx].ncyc, instret, failures - f0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    opcode    = 7'd0;
    is_ebreak = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    imem_gnt  = 1'b0;
    dmem_gnt  = 1'b0;

    //           name        op          eb    mr    mw    rw   ncyc imask     dmask     trace                irmask    pcmask    rfmask    ill   ret
    vecs[0]  = '{"op",       7'b0110011, 1'b0, 1'b0, 1'b0, 1'b1, 5,  16'h0001, 16'h0000, 64'h04210,           16'h0001, 16'h0008, 16'h0008, 1'b0, 32'd1};
    vecs[1]  = '{"load_dly", 7'b0000011, 1'b0, 1'b1, 1'b0, 1'b1, 10, 16'h0022, 16'h0081, 64'h0433332100,      16'h0002, 16'h0100, 16'h0100, 1'b0, 32'd1};
    vecs[2]  = '{"store",    7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0, 5,  16'h0001, 16'h0008, 64'h03210,           16'h0001, 16'h0008, 16'h0000, 1'b0, 32'd1};
    vecs[3]  = '{"branch",   7'b1100011, 1'b0, 1'b0, 1'b0, 1'b0, 4,  16'h0001, 16'h0000, 64'h0210,            16'h0001, 16'h0004, 16'h0000, 1'b0, 32'd1};
    vecs[4]  = '{"ill_7f",   7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0, 5,  16'h001F, 16'h001F, 64'h55510,           16'h0001, 16'h0000, 16'h0000, 1'b1, 32'd0};
    vecs[5]  = '{"ebreak",   7'b1110011, 1'b1, 1'b0, 1'b0, 1'b0, 5,  16'h001F, 16'h001F, 64'h55510,           16'h0001, 16'h0000, 16'h0000, 1'b0, 32'd0};
    vecs[6]  = '{"ill_00",   7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 3,  16'h0001, 16'h0000, 64'h510,             16'h0001, 16'h0000, 16'h0000, 1'b1, 32'd0};
    vecs[7]  = '{"lui",      7'b0110111, 1'b0, 1'b0, 1'b0, 1'b1, 5,  16'h0001, 16'h0000, 64'h04210,           16'h0001, 16'h0008, 16'h0008, 1'b0, 32'd1};
    vecs[8]  = '{"fence",    7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0, 4,  16'h0001, 16'h0000, 64'h0210,            16'h0001, 16'h0004, 16'h0000, 1'b0, 32'd1};
    vecs[9]  = '{"ecall",    7'b1110011, 1'b0, 1'b0, 1'b0, 1'b0, 4,  16'h0001, 16'h0000, 64'h0210,            16'h0001, 16'h0004, 16'h0000, 1'b0, 32'd1};
    vecs[10] = '{"jal",      7'b1101111, 1'b0, 1'b0, 1'b0, 1'b1, 5,  16'h0001, 16'h0000, 64'h04210,           16'h0001, 16'h0008, 16'h0008, 1'b0, 32'd1};
    vecs[11] = '{"load_now", 7'b0000011, 1'b0, 1'b1, 1'b0, 1'b1, 6,  16'h0001, 16'h0008, 64'h043210,          16'h0001, 16'h0010, 16'h0010, 1'b0, 32'd1};
    vecs[12] = '{"opimm_dly",7'b0010011, 1'b0, 1'b0, 1'b0, 1'b1, 7,  16'h0004, 16'h0000, 64'h0421000,         16'h0004, 16'h0020, 16'h0020, 1'b0, 32'd1};

    // Values held while reset is asserted.
    #2;
    chk("reset {st,ireq,irwe,dreq,pcwe,rfwe,halt,ill}",
        {22'd0, state, imem_req, ir_we, dmem_req, pc_we, rf_we, halted, illegal},
        {22'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset instret", instret, 32'd0);

    for (int v = 0; v < 13; v++) begin
      run_vec(v);
    end

    // Retire one OP, start a LOAD, then drop reset mid-cycle while in MEM.
    do_reset();
    opcode = 7'b0110011; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b1; is_ebreak = 1'b0;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick(); tick(); tick();
    chk("rstmem op retired", instret, 32'd1);
    opcode = 7'b0000011; mem_read = 1'b1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick(); tick();
    chk("rstmem in MEM {st,dreq}", {28'd0, state, dmem_req}, {28'd0, 3'd3, 1'b1});
    #2;
    rst_n    = 1'b0;
    dmem_gnt = 1'b1;
    #1;
    chk("rstmem async {st,ireq,dreq,pcwe,rfwe}",
        {25'd0, state, imem_req, dmem_req, pc_we, rf_we},
        {25'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rstmem async instret", instret, 32'd0);
    tick();
    chk("rstmem grant under reset {st,pcwe}", {28'd0, state, pc_we}, {28'd0, 3'd0, 1'b0});
    chk("rstmem instret held", instret, 32'd0);
    rst_n    = 1'b1;
    dmem_gnt = 1'b0;
    $display("seq reset_in_mem state=%0d instret=%0d", state, instret);

    // Counter wrap: preload all-ones, then retire a branch.
    do_reset();
    opcode = 7'b1100011; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    #1;
    chk("wrap preload", instret, 32'hFFFF_FFFF);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    chk("wrap pc_we in EXEC", {31'd0, pc_we}, 32'd1);
    tick();
    chk("wrap instret", instret, 32'd0);
    chk("wrap back to FETCH", {29'd0, state}, 32'd0);
    $display("seq instret_wrap instret=0x%08h", instret);

    // Unused encoding recovers to FETCH on the next edge.
    do_reset();
    force dut.state_reg = 3'd6;
    #1;
    release dut.state_reg;
    #1;
    chk("unused state visible", {29'd0, state}, 32'd6);
    tick();
    chk("unused state -> FETCH", {29'd0, state}, 32'd0);
    $display("seq unused_state state=%0d", state);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
